// File: rtl/display_capture.sv
// Recovers the 16 green LEDs, 16 red LEDs and 6 hex digits from the VGA overlay sync/colour stream.
// Latency: one input register stage; a frame's result appears at the start of COMMIT_LINE of that frame.
// Backpressure: none; passive monitor, outputs hold their value between commits.
module display_capture #(
    parameter int   NUM_RED_LEDS   = 16,
    parameter int   NUM_GREEN_LEDS = 16,
    parameter int   NUM_SEGMENTS   = 6,
    parameter logic SYNC_POL       = 1'b1,
    parameter int   H_OFFSET       = 220,
    parameter int   V_OFFSET       = 20,
    parameter int   COMMIT_LINE    = 220
) (
    input  logic                      clk_video,
    input  logic                      reset,
    input  logic                      hsync,
    input  logic                      vsync,
    input  logic [3:0]                r,
    input  logic [3:0]                g,
    input  logic [3:0]                b,
    output logic [NUM_RED_LEDS-1:0]   red_leds,
    output logic [NUM_GREEN_LEDS-1:0] green_leds,
    output logic [4*NUM_SEGMENTS-1:0] segments,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      locked
);

    localparam int SEG_W = 4 * NUM_SEGMENTS;

    localparam logic [11:0] X_MAX  = 12'd4095;
    localparam logic [11:0] X_PIX0 = 12'(H_OFFSET);

    // The line counter runs through negative values after a vsync reload, so it
    // is kept one bit wider than the 11-bit visible range and treated as signed.
    localparam logic signed [11:0] LINE_MAX    = 12'sd2047;
    localparam logic signed [11:0] LINE_RELOAD = 12'(-V_OFFSET);
    localparam logic signed [11:0] LN_COMMIT   = 12'(COMMIT_LINE);
    localparam logic signed [11:0] LN_GREEN    = 12'sd72;
    localparam logic signed [11:0] LN_RED      = 12'sd104;
    localparam logic signed [11:0] LN_SEG_A    = 12'sd154;
    localparam logic signed [11:0] LN_SEG_BF   = 12'sd168;
    localparam logic signed [11:0] LN_SEG_G    = 12'sd184;
    localparam logic signed [11:0] LN_SEG_CE   = 12'sd200;
    localparam logic signed [11:0] LN_SEG_D    = 12'sd216;

    // Segment probe columns inside a 64-pixel digit cell.
    localparam logic [5:0] OFF_MID   = 6'd44;
    localparam logic [5:0] OFF_RIGHT = 6'd60;
    localparam logic [5:0] OFF_LEFT  = 6'd28;

    // Stage-1 input registers and their one-cycle-older sync copies
    logic                      hs1_q, vs1_q, hs2_q, vs2_q;
    logic [3:0]                r1_q, g1_q, b1_q;

    // Timing state
    logic [11:0]               x_q, x_d, x_cur;
    logic signed [11:0]        line_q, line_d;
    logic                      locked_q, locked_d;

    // Per-frame shadows
    logic [NUM_GREEN_LEDS-1:0] green_sh_q, green_sh_d;
    logic [NUM_RED_LEDS-1:0]   red_sh_q, red_sh_d;
    logic [NUM_SEGMENTS-1:0][6:0] seg_sh_q, seg_sh_d;
    logic                      err_q, err_d;

    // Committed outputs
    logic [NUM_GREEN_LEDS-1:0] green_q, green_d;
    logic [NUM_RED_LEDS-1:0]   red_q, red_d;
    logic [SEG_W-1:0]          seg_q, seg_d;
    logic                      fv_q, fv_d;
    logic                      ferr_q, ferr_d;

    // Combinational helpers
    logic                      hs_edge, vs_edge;
    logic                      pix_ok, led_hit, dig_ok, seg_hit, commit;
    logic [11:0]               pix;
    logic [3:0]                led_bit;
    logic [2:0]                dig_k, seg_bit;
    logic [5:0]                dig_off;
    logic                      is_g1, is_g0, is_r1, is_r0, is_y1, is_y0;
    logic [4:0]                dec;
    logic                      dec_err;

    // Segment pattern (bit0=a .. bit6=g) back to a hex nibble; bit 4 flags an unknown pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'd63:   res = 5'h00;
            7'd6:    res = 5'h01;
            7'd91:   res = 5'h02;
            7'd79:   res = 5'h03;
            7'd102:  res = 5'h04;
            7'd109:  res = 5'h05;
            7'd125:  res = 5'h06;
            7'd7:    res = 5'h07;
            7'd127:  res = 5'h08;
            7'd111:  res = 5'h09;
            7'd119:  res = 5'h0A;
            7'd124:  res = 5'h0B;
            7'd57:   res = 5'h0C;
            7'd94:   res = 5'h0D;
            7'd121:  res = 5'h0E;
            7'd113:  res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    // Sync edge detection and the x / line position of the current stage-1 sample
    always_comb begin
        hs_edge = (hs2_q == SYNC_POL) && (hs1_q != SYNC_POL);
        vs_edge = (vs2_q == SYNC_POL) && (vs1_q != SYNC_POL);

        x_cur = hs_edge ? 12'd0 : x_q;
        x_d   = (x_cur == X_MAX) ? x_cur : x_cur + 12'd1;

        // A vsync edge wins over a coincident hsync edge so that the first
        // counted line after the reload is always 1-V_OFFSET.
        line_d = line_q;
        if (vs_edge) begin
            line_d = LINE_RELOAD;
        end else if (hs_edge && (line_q != LINE_MAX)) begin
            line_d = line_q + 12'sd1;
        end
    end

    // Map the current x/line onto LED slots and segment probe points
    always_comb begin
        pix_ok  = (x_cur >= X_PIX0);
        pix     = x_cur - X_PIX0;
        led_hit = pix_ok && (pix < 12'd512) && (pix[4:0] == 5'd24);
        led_bit = 4'd15 - pix[8:5];
        dig_ok  = pix_ok && (pix < 12'd384);
        dig_k   = pix[8:6];
        dig_off = pix[5:0];

        seg_hit = 1'b0;
        seg_bit = 3'd0;
        if (dig_ok) begin
            if (line_d == LN_SEG_A && dig_off == OFF_MID) begin
                seg_hit = 1'b1; seg_bit = 3'd0;
            end else if (line_d == LN_SEG_BF && dig_off == OFF_RIGHT) begin
                seg_hit = 1'b1; seg_bit = 3'd1;
            end else if (line_d == LN_SEG_BF && dig_off == OFF_LEFT) begin
                seg_hit = 1'b1; seg_bit = 3'd5;
            end else if (line_d == LN_SEG_G && dig_off == OFF_MID) begin
                seg_hit = 1'b1; seg_bit = 3'd6;
            end else if (line_d == LN_SEG_CE && dig_off == OFF_RIGHT) begin
                seg_hit = 1'b1; seg_bit = 3'd2;
            end else if (line_d == LN_SEG_CE && dig_off == OFF_LEFT) begin
                seg_hit = 1'b1; seg_bit = 3'd4;
            end else if (line_d == LN_SEG_D && dig_off == OFF_MID) begin
                seg_hit = 1'b1; seg_bit = 3'd3;
            end
        end
    end

    // Classify the stage-1 colour against the lit / unlit colours of each element
    always_comb begin
        is_g1 = (g1_q == 4'hF) && (r1_q == 4'h0) && (b1_q == 4'h0);
        is_g0 = (g1_q == 4'h3) && (r1_q == 4'h0) && (b1_q == 4'h0);
        is_r1 = (r1_q == 4'hF) && (g1_q == 4'h0) && (b1_q == 4'h0);
        is_r0 = (r1_q == 4'h3) && (g1_q == 4'h0) && (b1_q == 4'h0);
        is_y1 = (r1_q == 4'hF) && (g1_q == 4'hF) && (b1_q == 4'h0);
        is_y0 = (r1_q == 4'h3) && (g1_q == 4'h3) && (b1_q == 4'h0);
    end

    // Shadow sampling, frame commit and per-frame clearing
    always_comb begin
        green_sh_d = green_sh_q;
        red_sh_d   = red_sh_q;
        seg_sh_d   = seg_sh_q;
        err_d      = err_q;
        locked_d   = locked_q;
        green_d    = green_q;
        red_d      = red_q;
        seg_d      = seg_q;
        ferr_d     = ferr_q;
        fv_d       = 1'b0;
        dec        = 5'd0;
        dec_err    = 1'b0;

        if (led_hit && line_d == LN_GREEN) begin
            green_sh_d[led_bit] = is_g1;
            if (!(is_g1 || is_g0)) err_d = 1'b1;
        end
        if (led_hit && line_d == LN_RED) begin
            red_sh_d[led_bit] = is_r1;
            if (!(is_r1 || is_r0)) err_d = 1'b1;
        end
        if (seg_hit) begin
            seg_sh_d[dig_k][seg_bit] = is_y1;
            if (!(is_y1 || is_y0)) err_d = 1'b1;
        end

        commit = hs_edge && !vs_edge && locked_q && (line_d == LN_COMMIT);
        if (commit) begin
            green_d = green_sh_q;
            red_d   = red_sh_q;
            for (int k = 0; k < NUM_SEGMENTS; k++) begin
                dec = seg_decode(seg_sh_q[k]);
                seg_d[4*(NUM_SEGMENTS-1-k) +: 4] = dec[3:0];
                dec_err = dec_err | dec[4];
            end
            ferr_d = err_q | dec_err;
            fv_d   = 1'b1;
        end

        // Each frame starts from clean shadows; partial frames are dropped here.
        if (commit || vs_edge) begin
            green_sh_d = '0;
            red_sh_d   = '0;
            seg_sh_d   = '0;
            err_d      = 1'b0;
        end
        if (vs_edge) locked_d = 1'b1;
    end

    // All state: stage-1 inputs, timing, shadows and committed outputs
    always_ff @(posedge clk_video or negedge reset) begin
        if (!reset) begin
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            x_q        <= '0;
            line_q     <= '0;
            locked_q   <= 1'b0;
            green_sh_q <= '0;
            red_sh_q   <= '0;
            seg_sh_q   <= '0;
            err_q      <= 1'b0;
            green_q    <= '0;
            red_q      <= '0;
            seg_q      <= '0;
            fv_q       <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            hs1_q      <= hsync;
            vs1_q      <= vsync;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            r1_q       <= r;
            g1_q       <= g;
            b1_q       <= b;
            x_q        <= x_d;
            line_q     <= line_d;
            locked_q   <= locked_d;
            green_sh_q <= green_sh_d;
            red_sh_q   <= red_sh_d;
            seg_sh_q   <= seg_sh_d;
            err_q      <= err_d;
            green_q    <= green_d;
            red_q      <= red_d;
            seg_q      <= seg_d;
            fv_q       <= fv_d;
            ferr_q     <= ferr_d;
        end
    end

    assign green_leds  = green_q;
    assign red_leds    = red_q;
    assign segments    = seg_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_display_capture.sv
// Bench for display_capture: a synthetic display paints LED/digit pixels from chosen values.
// Latency: results are expected at the commit line of the same frame.
// Backpressure: none; the capture block is a passive monitor.
module tb_display_capture;

    logic        clk_video = 1'b0;
    logic        reset;
    logic        hsync, vsync;
    logic [3:0]  r, g, b;
    logic [15:0] red_leds, green_leds;
    logic [23:0] segments;
    logic        frame_valid, frame_err, locked;

    int checks = 0;
    int passed = 0;

    always #5 clk_video = ~clk_video;

    display_capture dut (
        .clk_video   (clk_video),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .r           (r),
        .g           (g),
        .b           (b),
        .red_leds    (red_leds),
        .green_leds  (green_leds),
        .segments    (segments),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .locked      (locked)
    );

    // What the display is currently painting
    logic [15:0] disp_g, disp_r;
    logic [23:0] disp_s;
    bit          inj_err;

    // Digit glyphs 0..F, bit0=a .. bit6=g
    logic [6:0] seg_tab [16] = '{7'd63, 7'd6, 7'd91, 7'd79, 7'd102, 7'd109, 7'd125, 7'd7,
                                 7'd127, 7'd111, 7'd119, 7'd124, 7'd57, 7'd94, 7'd121, 7'd113};
    // Segment probe points: line, column inside the digit cell, pattern bit
    int seg_line [7] = '{154, 168, 168, 184, 200, 200, 216};
    int seg_off  [7] = '{44, 60, 28, 44, 60, 28, 44};
    int seg_idx  [7] = '{0, 1, 5, 6, 2, 4, 3};

    // Frame-valid monitor
    int          fv_cnt = 0;
    logic [15:0] cap_g, cap_r;
    logic [23:0] cap_s;
    logic        cap_e;

    always @(negedge clk_video) begin
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            cap_g = green_leds;
            cap_r = red_leds;
            cap_s = segments;
            cap_e = frame_err;
        end
    end

    // Colour of display pixel p on the given capture line: {defined, r, g, b}
    function automatic logic [12:0] pixel_model(input int line, input int p);
        logic [12:0] px;
        logic [3:0]  nib;
        logic        on;
        px = '0;
        if ((line == 72 || line == 104) && p < 512 && p % 32 == 24) begin
            if (line == 72) begin
                on = disp_g[15 - p / 32];
                px = on ? 13'h10F0 : 13'h1030;
            end else begin
                on = disp_r[15 - p / 32];
                px = on ? 13'h1F00 : 13'h1300;
            end
        end
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 6; k++) begin
                if (line == seg_line[j] && p == 64 * k + seg_off[j]) begin
                    nib = disp_s[4 * (5 - k) +: 4];
                    on  = seg_tab[nib][seg_idx[j]];
                    px  = on ? 13'h1FF0 : 13'h1330;
                end
            end
        end
        if (inj_err && line == 154 && p == 44) px[3:0] = 4'hF;
        return px;
    endfunction

    // One display line; frame line L maps to capture line L-21. Lines without
    // content are kept short; hold stretches the hsync-inactive period with
    // blue noise that would be flagged if it were ever sampled.
    task automatic drive_line(input int L, input int hold);
        int          line, len;
        logic [12:0] px;
        line = L - 21;
        len  = 2;
        if (line == 72 || line == 104) len = 220 + 505;
        else if (line inside {154, 168, 184, 200, 216}) len = 220 + 381;
        for (int c = 0; c < 2 + len + hold; c++) begin
            @(posedge clk_video); #1;
            hsync = (c < 2);
            vsync = (L < 2);
            px = (c >= 222 && c < 2 + len) ? pixel_model(line, c - 222) : 13'd0;
            if (c >= 2 + len)  {r, g, b} = 12'h00F;
            else if (px[12])   {r, g, b} = px[11:0];
            else               {r, g, b} = 12'($urandom);
        end
    endtask

    task automatic run_lines(input int l0, input int l1);
        for (int L = l0; L <= l1; L++) drive_line(L, 0);
    endtask

    task automatic random_content();
        disp_g = 16'($urandom);
        disp_r = 16'($urandom);
        disp_s = 24'($urandom);
    endtask

    task automatic test_reset();
        int fv0;
        reset = 1'b0;
        repeat (3) @(posedge clk_video);
        @(negedge clk_video);
        checks++;
        if ({green_leds, red_leds, segments, frame_valid, frame_err} !== 58'd0)
            $display("FAIL reset_outputs: got %h required 0", {green_leds, red_leds, segments, frame_valid, frame_err});
        else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b required 0", locked);
        else passed++;

        @(posedge clk_video); #1 reset = 1'b1;
        random_content();
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL first_frame_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL first_frame_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
        checks++;
        if (locked !== 1'b1) $display("FAIL locked_after_vsync: got %b required 1", locked);
        else passed++;

        random_content();
        run_lines(0, 120);
        @(posedge clk_video); #1 reset = 1'b0;
        repeat (3) @(posedge clk_video);
        @(negedge clk_video);
        checks++;
        if ({green_leds, red_leds, segments, frame_valid, frame_err} !== 58'd0)
            $display("FAIL midframe_reset_outputs: got %h required 0", {green_leds, red_leds, segments, frame_valid, frame_err});
        else passed++;
        checks++;
        if (locked !== 1'b0) $display("FAIL midframe_reset_locked: got %b required 0", locked);
        else passed++;
        @(posedge clk_video); #1 reset = 1'b1;
        fv0 = fv_cnt;
        run_lines(121, 245);
        checks++;
        if (fv_cnt != fv0) $display("FAIL no_commit_before_relock: got %0d pulses required 0", fv_cnt - fv0);
        else passed++;

        random_content();
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL relock_frame_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL relock_frame_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
    endtask

    task automatic test_basic();
        int fv0;
        disp_g = 16'hA5C3;
        disp_r = 16'h0001;
        disp_s = 24'h012345;
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL basic_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {16'hA5C3, 16'h0001, 24'h012345, 1'b0})
            $display("FAIL basic_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {16'hA5C3, 16'h0001, 24'h012345, 1'b0});
        else passed++;
        checks++;
        if ({green_leds, red_leds, segments} !== {16'hA5C3, 16'h0001, 24'h012345})
            $display("FAIL basic_hold: got %h required %h", {green_leds, red_leds, segments}, {16'hA5C3, 16'h0001, 24'h012345});
        else passed++;

        random_content();
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL random_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL random_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [2] = '{24'hFEDCBA, 24'h89ABCD};
        int fv0;
        for (int i = 0; i < 2; i++) begin
            disp_g = 16'($urandom);
            disp_r = 16'($urandom);
            disp_s = vals[i];
            fv0 = fv_cnt;
            run_lines(0, 245);
            checks++;
            if (fv_cnt - fv0 != 1) $display("FAIL b2b_fv%0d: got %0d pulses required 1", i, fv_cnt - fv0);
            else passed++;
            checks++;
            if ({cap_s, cap_e} !== {vals[i], 1'b0})
                $display("FAIL b2b_segments%0d: got %h required %h", i, {cap_s, cap_e}, {vals[i], 1'b0});
            else passed++;
        end
    endtask

    task automatic test_pixel_error();
        int fv0;
        random_content();
        inj_err = 1'b1;
        fv0 = fv_cnt;
        run_lines(0, 245);
        inj_err = 1'b0;
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL err_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if (cap_e !== 1'b1) $display("FAIL err_flag: got %b required 1", cap_e);
        else passed++;
        checks++;
        if ({cap_g, cap_r} !== {disp_g, disp_r})
            $display("FAIL err_leds: got %h required %h", {cap_g, cap_r}, {disp_g, disp_r});
        else passed++;

        random_content();
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL clean_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL clean_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
    endtask

    task automatic test_vsync_cut();
        logic [55:0] prev;
        int          fv0;
        prev = {disp_g, disp_r, disp_s};
        random_content();
        fv0 = fv_cnt;
        run_lines(0, 171);
        checks++;
        if (fv_cnt != fv0) $display("FAIL cut_no_fv: got %0d pulses required 0", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({green_leds, red_leds, segments} !== prev)
            $display("FAIL cut_hold: got %h required %h", {green_leds, red_leds, segments}, prev);
        else passed++;

        random_content();
        fv0 = fv_cnt;
        run_lines(0, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL after_cut_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL after_cut_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
    endtask

    task automatic test_hsync_hold();
        int fv0;
        random_content();
        fv0 = fv_cnt;
        run_lines(0, 92);
        drive_line(93, 5000);
        checks++;
        if (fv_cnt != fv0) $display("FAIL hold_no_fv: got %0d pulses required 0", fv_cnt - fv0);
        else passed++;
        run_lines(94, 245);
        checks++;
        if (fv_cnt - fv0 != 1) $display("FAIL hold_fv: got %0d pulses required 1", fv_cnt - fv0);
        else passed++;
        checks++;
        if ({cap_g, cap_r, cap_s, cap_e} !== {disp_g, disp_r, disp_s, 1'b0})
            $display("FAIL hold_data: got %h required %h", {cap_g, cap_r, cap_s, cap_e}, {disp_g, disp_r, disp_s, 1'b0});
        else passed++;
    endtask

    initial begin
        reset   = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        r       = 4'h0;
        g       = 4'h0;
        b       = 4'h0;
        inj_err = 1'b0;
        disp_g  = '0;
        disp_r  = '0;
        disp_s  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_pixel_error();
        test_vsync_cut();
        test_hsync_hold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
